// File: rtl/arp_req_arb.sv
// arp_req_arb
// Shares the single ARP request/response interface of the arp block among
// S_COUNT requesters. A round-robin arbiter picks one requester, and only one
// lookup is in flight at a time. The grant is held from request acceptance
// until the response has been delivered back to that requester. An optional
// watchdog (TIMEOUT != 0) returns an error to a stalled requester. It then
// drains the orphaned downstream response so that the response cannot be
// handed to the next requester.
//
// Valid/ready semantics on every channel: a transfer happens on a rising clk
// edge where valid and ready are both 1. A source holds valid and its payload
// stable until that transfer. It may not withdraw valid before ready.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_arp_request_valid/ready    per-requester request handshake
//   s_arp_request_ip             requester i IP at [32*i +: 32]
//   s_arp_response_valid/ready   per-requester response handshake
//   s_arp_response_error         response error, only on the granted bit
//   s_arp_response_mac           latched MAC, shared by all requesters
//   m_arp_request_valid/ready/ip downstream request to the arp block
//   m_arp_response_valid/ready   downstream response handshake
//   m_arp_response_error/mac     downstream response payload
//   busy                         arbiter is not idle
//   timeout_event                one-cycle pulse when the watchdog fires

module arp_req_arb #(
    parameter int S_COUNT = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [S_COUNT-1:0]     s_arp_request_valid,
    output logic [S_COUNT-1:0]     s_arp_request_ready,
    input  logic [S_COUNT*32-1:0]  s_arp_request_ip,
    output logic [S_COUNT-1:0]     s_arp_response_valid,
    input  logic [S_COUNT-1:0]     s_arp_response_ready,
    output logic [S_COUNT-1:0]     s_arp_response_error,
    output logic [47:0]            s_arp_response_mac,

    output logic                   m_arp_request_valid,
    input  logic                   m_arp_request_ready,
    output logic [31:0]            m_arp_request_ip,
    input  logic                   m_arp_response_valid,
    output logic                   m_arp_response_ready,
    input  logic                   m_arp_response_error,
    input  logic [47:0]            m_arp_response_mac,

    output logic                   busy,
    output logic                   timeout_event
);

    localparam int CL_S = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CL_S-1:0] G_LAST = CL_S'(S_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CL_S-1:0] ptr;
    logic [CL_S-1:0] grant_reg;
    logic [CL_S-1:0] grant_sel;
    logic            grant_found;
    logic [31:0]     ip_reg;
    logic [47:0]     mac_reg;
    logic            err_reg;
    logic            drain_reg;
    logic [TW-1:0]   timer;
    logic            timeout_pulse;
    logic            wd_hit;
    logic            deliver_done;

    // The watchdog limit is reached on the TIMEOUT-th cycle spent in WAIT or
    // DRAIN. The timer restarts from 0 on entry to either state.
    assign wd_hit = (TIMEOUT != 0) && (timer == T_LAST);

    assign deliver_done = s_arp_response_ready[grant_reg];

    // Round-robin search. The first valid requester at or above ptr wins,
    // and the search wraps around to index 0.
    always_comb begin
        int idx;
        grant_sel   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = int'(ptr) + i;
            if (idx >= S_COUNT) begin
                idx = idx - S_COUNT;
            end
            if (!grant_found && s_arp_request_valid[CL_S'(idx)]) begin
                grant_sel   = CL_S'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_found) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (m_arp_request_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A real response takes priority over a same-cycle timeout.
                if (m_arp_response_valid || wd_hit) state_next = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (deliver_done) state_next = drain_reg ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (m_arp_response_valid || wd_hit) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: grant, latched payloads, pointer, watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            grant_reg     <= '0;
            ip_reg        <= '0;
            mac_reg       <= '0;
            err_reg       <= 1'b0;
            drain_reg     <= 1'b0;
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_reg <= grant_sel;
                        ip_reg    <= s_arp_request_ip[32*grant_sel +: 32];
                        drain_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (m_arp_response_valid) begin
                        mac_reg <= m_arp_response_mac;
                        err_reg <= m_arp_response_error;
                    end else if (wd_hit) begin
                        // The arp block still owes a response, so swallow it
                        // in DRAIN after the error has been delivered.
                        err_reg       <= 1'b1;
                        drain_reg     <= 1'b1;
                        timeout_pulse <= 1'b1;
                    end
                end
                ST_DELIVER: begin
                    if (deliver_done) begin
                        ptr <= (grant_reg == G_LAST) ? '0 : grant_reg + 1'b1;
                    end
                end
                default: ;
            endcase

            // The timer runs only while the state stays WAIT or DRAIN. It
            // saturates instead of wrapping.
            if ((state == ST_WAIT || state == ST_DRAIN) && state_next == state) begin
                if (timer != '1) timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    // Output logic
    always_comb begin
        s_arp_request_ready  = '0;
        s_arp_response_valid = '0;
        s_arp_response_error = '0;
        if (state == ST_IDLE && grant_found) begin
            s_arp_request_ready[grant_sel] = 1'b1;
        end
        if (state == ST_DELIVER) begin
            s_arp_response_valid[grant_reg] = 1'b1;
            s_arp_response_error[grant_reg] = err_reg;
        end
        s_arp_response_mac   = mac_reg;
        m_arp_request_valid  = (state == ST_REQ);
        m_arp_request_ip     = ip_reg;
        m_arp_response_ready = (state == ST_WAIT) || (state == ST_DRAIN);
        busy                 = (state != ST_IDLE);
        timeout_event        = timeout_pulse;
    end

endmodule

// File: tb/tb_arp_req_arb.sv
// tb_arp_req_arb
// Directed bench for arp_req_arb with S_COUNT=2 and TIMEOUT=16. A table of
// lookups, each with its expected grant, covers round-robin order, error
// responses and pointer wrap. Hand-written sequences cover the downstream
// stalls, the watchdog and drain path, and a reset taken in WAIT.

module tb_arp_req_arb;

    localparam int S_COUNT = 2;
    localparam int TIMEOUT = 16;

    logic                  clk;
    logic                  rst;
    logic [S_COUNT-1:0]    s_arp_request_valid;
    logic [S_COUNT-1:0]    s_arp_request_ready;
    logic [S_COUNT*32-1:0] s_arp_request_ip;
    logic [S_COUNT-1:0]    s_arp_response_valid;
    logic [S_COUNT-1:0]    s_arp_response_ready;
    logic [S_COUNT-1:0]    s_arp_response_error;
    logic [47:0]           s_arp_response_mac;
    logic                  m_arp_request_valid;
    logic                  m_arp_request_ready;
    logic [31:0]           m_arp_request_ip;
    logic                  m_arp_response_valid;
    logic                  m_arp_response_ready;
    logic                  m_arp_response_error;
    logic [47:0]           m_arp_response_mac;
    logic                  busy;
    logic                  timeout_event;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] cur_ip [S_COUNT];

    arp_req_arb #(.S_COUNT(S_COUNT), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_arp_request_valid  (s_arp_request_valid),
        .s_arp_request_ready  (s_arp_request_ready),
        .s_arp_request_ip     (s_arp_request_ip),
        .s_arp_response_valid (s_arp_response_valid),
        .s_arp_response_ready (s_arp_response_ready),
        .s_arp_response_error (s_arp_response_error),
        .s_arp_response_mac   (s_arp_response_mac),
        .m_arp_request_valid  (m_arp_request_valid),
        .m_arp_request_ready  (m_arp_request_ready),
        .m_arp_request_ip     (m_arp_request_ip),
        .m_arp_response_valid (m_arp_response_valid),
        .m_arp_response_ready (m_arp_response_ready),
        .m_arp_response_error (m_arp_response_error),
        .m_arp_response_mac   (m_arp_response_mac),
        .busy                 (busy),
        .timeout_event        (timeout_event)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so that a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "time limit");
    end

    // Table record: requests to raise, the IPs to drive, and the arp answer,
    // with the grant expected for this lookup.
    typedef struct {
        logic [1:0]  raise;
        logic [31:0] ip0;
        logic [31:0] ip1;
        int          delay;
        logic [47:0] mac;
        logic        err;
        int          exp_g;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [1:0] oh(input int g);
        logic [1:0] one;
        one = 2'b01;
        return one << g;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock, then sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_reqs(input logic [1:0] mask, input logic [31:0] ip0, input logic [31:0] ip1);
        if (mask[0]) begin
            cur_ip[0] = ip0;
            s_arp_request_ip[31:0] = ip0;
            s_arp_request_valid[0] = 1'b1;
        end
        if (mask[1]) begin
            cur_ip[1] = ip1;
            s_arp_request_ip[63:32] = ip1;
            s_arp_request_valid[1] = 1'b1;
        end
    endtask

    // Full lookup for expected grant g. Called with the pending requests
    // already driven.
    task automatic serve(input int g, input int delay, input logic [47:0] mac, input logic err);
        #1;
        check("req_ready", 64'(s_arp_request_ready), 64'(oh(g)));
        step();
        s_arp_request_valid[g] = 1'b0;
        check("m_req_valid", 64'(m_arp_request_valid), 64'd1);
        check("m_req_ip", 64'(m_arp_request_ip), 64'(cur_ip[g]));
        m_arp_request_ready = 1'b1;
        step();
        m_arp_request_ready = 1'b0;
        check("m_resp_ready", 64'(m_arp_response_ready), 64'd1);
        repeat (delay) step();
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = mac;
        m_arp_response_error = err;
        step();
        m_arp_response_valid = 1'b0;
        check("resp_valid", 64'(s_arp_response_valid), 64'(oh(g)));
        check("resp_error", 64'(s_arp_response_error), err ? 64'(oh(g)) : 64'd0);
        check("resp_mac", 64'(s_arp_response_mac), 64'(mac));
        s_arp_response_ready = oh(g);
        step();
        s_arp_response_ready = '0;
        check("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [47:0] held_mac;
        logic [31:0] held_ip;

        vecs[0] = '{2'b11, 32'hC0A80001, 32'hC0A80002, 2, 48'h001122334455, 1'b0, 0};
        vecs[1] = '{2'b00, 32'h0,        32'h0,        4, 48'h0A0B0C0D0E0F, 1'b0, 1};
        vecs[2] = '{2'b11, 32'h0A000001, 32'h0A000002, 1, 48'h111111111111, 1'b0, 0};
        vecs[3] = '{2'b00, 32'h0,        32'h0,        5, 48'h222222222222, 1'b0, 1};
        vecs[4] = '{2'b01, 32'hC0A80101, 32'h0,        3, 48'h5A5152535455, 1'b0, 0};
        vecs[5] = '{2'b10, 32'h0,        32'hC0A80202, 0, 48'h665544332211, 1'b1, 1};
        vecs[6] = '{2'b10, 32'h0,        32'hC0A80203, 2, 48'h777777777777, 1'b0, 1};
        vecs[7] = '{2'b01, 32'hC0A80102, 32'h0,        1, 48'h888888888888, 1'b0, 0};
        vecs[8] = '{2'b01, 32'hC0A80103, 32'h0,        2, 48'h999999999999, 1'b0, 0};

        rst                  = 1'b1;
        s_arp_request_valid  = '0;
        s_arp_request_ip     = '0;
        s_arp_response_ready = '0;
        m_arp_request_ready  = 1'b0;
        m_arp_response_valid = 1'b0;
        m_arp_response_error = 1'b0;
        m_arp_response_mac   = '0;
        cur_ip[0] = '0;
        cur_ip[1] = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m_req_valid", 64'(m_arp_request_valid), 64'd0);
        check("rst_m_resp_ready", 64'(m_arp_response_ready), 64'd0);
        check("rst_resp_valid", 64'(s_arp_response_valid), 64'd0);
        check("rst_req_ready", 64'(s_arp_request_ready), 64'd0);
        check("rst_timeout", 64'(timeout_event), 64'd0);
        check("rst_mac", 64'(s_arp_response_mac), 64'd0);
        check("rst_ip", 64'(m_arp_request_ip), 64'd0);

        // Table of lookups: round robin, errors, pointer wrap
        for (int v = 0; v < 9; v++) begin
            raise_reqs(vecs[v].raise, vecs[v].ip0, vecs[v].ip1);
            serve(vecs[v].exp_g, vecs[v].delay, vecs[v].mac, vecs[v].err);
        end

        // Downstream stalls: request held for 10 cycles, response held for 7
        raise_reqs(2'b01, 32'hAC100001, 32'h0);
        #1;
        check("stall_req_ready", 64'(s_arp_request_ready), 64'd1);
        step();
        s_arp_request_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("stall_m_valid", 64'(m_arp_request_valid), 64'd1);
            check("stall_m_ip", 64'(m_arp_request_ip), 64'hAC100001);
            step();
        end
        m_arp_request_ready = 1'b1;
        step();
        m_arp_request_ready = 1'b0;
        repeat (2) step();
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'hABCDEF012345;
        m_arp_response_error = 1'b0;
        step();
        m_arp_response_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check("stall_resp_valid", 64'(s_arp_response_valid), 64'd1);
            check("stall_resp_mac", 64'(s_arp_response_mac), 64'hABCDEF012345);
            step();
        end
        s_arp_response_ready = 2'b01;
        step();
        s_arp_response_ready = '0;
        check("stall_idle", 64'(busy), 64'd0);

        // Watchdog: arp stays silent, requester 1 gets an error, and the late
        // response is drained
        raise_reqs(2'b10, 32'h0, 32'hAC100002);
        #1;
        check("to_req_ready", 64'(s_arp_request_ready), 64'd2);
        step();
        s_arp_request_valid[1] = 1'b0;
        m_arp_request_ready = 1'b1;
        step();
        m_arp_request_ready = 1'b0;
        repeat (15) step();
        check("to_still_wait", 64'(m_arp_response_ready), 64'd1);
        check("to_no_early_pulse", 64'(timeout_event), 64'd0);
        check("to_no_early_resp", 64'(s_arp_response_valid), 64'd0);
        step();
        check("to_pulse", 64'(timeout_event), 64'd1);
        check("to_resp_valid", 64'(s_arp_response_valid), 64'd2);
        check("to_resp_error", 64'(s_arp_response_error), 64'd2);
        step();
        check("to_pulse_one_cycle", 64'(timeout_event), 64'd0);
        check("to_resp_held", 64'(s_arp_response_valid), 64'd2);
        s_arp_response_ready = 2'b10;
        step();
        s_arp_response_ready = '0;
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_m_ready", 64'(m_arp_response_ready), 64'd1);
        check("drain_no_resp", 64'(s_arp_response_valid), 64'd0);
        repeat (4) step();
        m_arp_response_valid = 1'b1;
        m_arp_response_mac   = 48'hDEADBEEF0000;
        m_arp_response_error = 1'b0;
        #1;
        check("drain_not_fwd", 64'(s_arp_response_valid), 64'd0);
        step();
        m_arp_response_valid = 1'b0;
        check("drain_idle", 64'(busy), 64'd0);
        check("drain_no_resp2", 64'(s_arp_response_valid), 64'd0);
        raise_reqs(2'b01, 32'hAC100003, 32'h0);
        serve(0, 2, 48'h102030405060, 1'b0);

        // Reset taken in WAIT abandons the lookup and clears the pointer
        raise_reqs(2'b10, 32'h0, 32'hAC100004);
        #1;
        check("rw_req_ready", 64'(s_arp_request_ready), 64'd2);
        step();
        s_arp_request_valid[1] = 1'b0;
        held_ip = m_arp_request_ip;
        check("rw_m_ip", 64'(held_ip), 64'hAC100004);
        m_arp_request_ready = 1'b1;
        step();
        m_arp_request_ready = 1'b0;
        held_mac = s_arp_response_mac;
        check("rw_in_wait", 64'(m_arp_response_ready), 64'd1);
        rst = 1'b1;
        step();
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_m_ready", 64'(m_arp_response_ready), 64'd0);
        check("rw_m_valid", 64'(m_arp_request_valid), 64'd0);
        check("rw_resp_valid", 64'(s_arp_response_valid), 64'd0);
        check("rw_mac", 64'(s_arp_response_mac), 64'd0);
        check("rw_ip", 64'(m_arp_request_ip), 64'd0);
        rst = 1'b0;
        step();
        raise_reqs(2'b11, 32'hAC100005, 32'hAC100006);
        serve(0, 1, 48'h0000000000AA, 1'b0);
        serve(1, 1, 48'h0000000000BB, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
